data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/cache_pkg.sv | 27 ++
 rtl/data_cache_if.sv | 24 ++
 rtl/cache_store.sv | 47 ++++
 rtl/data_cache.sv | 193 +++++++++++++++++++
 tb/tb_data_cache.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
package cache_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned INDEX_BITS_DEF = 4;
  localparam int unsigned CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Saturating increment used by the hit/miss statistics counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (v == {CNT_WIDTH{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Backing-memory bus between the cache (master) and the memory (slave).
interface data_cache_if
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/cache_store.sv
// Valid/tag/data arrays with a combinational lookup port and one write port.
module cache_store #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = 26
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] lk_index_i,
  input  logic [TAG_BITS-1:0]   lk_tag_i,
  output logic                  lk_hit_o,
  output logic [DATA_WIDTH-1:0] lk_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);
  localparam int unsigned LINES = 32'd1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  // Valid bits are the only reset state; they gate every hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data storage, written together on a fill or a store hit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  // Combinational lookup so load hits add no latency.
  always_comb begin
    lk_hit_o  = valid_q[lk_index_i] && (tag_q[lk_index_i] == lk_tag_i);
    lk_data_o = data_q[lk_index_i];
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  data_cache_if.master          mem,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);
  localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic                  stall_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic [ADDR_WIDTH-1:0] lk_addr_s;
  logic [INDEX_BITS-1:0] lk_index_s;
  logic [TAG_BITS-1:0]   lk_tag_s;
  logic                  lk_hit_s;
  logic [DATA_WIDTH-1:0] lk_data_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic                  unused_addr_s;

  // Byte offset bits take no part in indexing or tagging.
  assign unused_addr_s = ^lk_addr_s[1:0];

  // Lookup uses the live address while idle, the latched one otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      lk_addr_s = addr_i;
    end else begin
      lk_addr_s = addr_q;
    end
    lk_index_s = lk_addr_s[INDEX_BITS+1:2];
    lk_tag_s   = lk_addr_s[ADDR_WIDTH-1:INDEX_BITS+2];
  end

  cache_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lk_index_i (lk_index_s),
    .lk_tag_i   (lk_tag_s),
    .lk_hit_o   (lk_hit_s),
    .lk_data_o  (lk_data_s),
    .wr_en_i    (wr_en_s),
    .wr_index_i (lk_index_s),
    .wr_tag_i   (lk_tag_s),
    .wr_data_i  (wr_data_s)
  );

  // Next-state, bus request and counter logic of the access FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    stall_s     = 1'b0;
    rdata_s     = '0;
    wr_en_s     = 1'b0;
    wr_data_s   = data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i && we_i) begin
          stall_s     = 1'b1;
          state_d     = ST_WRITE;
          addr_d      = addr_i;
          data_d      = wdata_i;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d = wdata_i;
          if (lk_hit_s) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
        end else if (req_i && lk_hit_s) begin
          rdata_s   = lk_data_s;
          hit_cnt_d = sat_inc(hit_cnt_q);
        end else if (req_i) begin
          stall_s    = 1'b1;
          state_d    = ST_FETCH;
          addr_d     = addr_i;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {addr_i[ADDR_WIDTH-1:2], 2'b00};
          miss_cnt_d = sat_inc(miss_cnt_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        stall_s = 1'b1;
        if (mem.mem_ack_i) begin
          wr_en_s   = 1'b1;
          wr_data_s = mem.mem_rdata_i;
          data_d    = mem.mem_rdata_i;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WRITE: begin
        stall_s = 1'b1;
        if (mem.mem_ack_i) begin
          // No write-allocate: only refresh a line that already holds this tag.
          wr_en_s   = lk_hit_s;
          wr_data_s = data_q;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_RESP: begin
        rdata_s = data_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched transaction and registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Pipeline-facing outputs are combinational and forced quiet during reset.
  assign stall_o         = rst_i & stall_s;
  assign rdata_o         = rst_i ? rdata_s : '0;
  assign mem.mem_req_o   = mem_req_q;
  assign mem.mem_we_o    = mem_we_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: driver queues expectations, monitor checks completions.
module tb_data_cache;
  logic        clk;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic [15:0] hit_cnt_o;
  logic [15:0] miss_cnt_o;

  data_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mif ();

  data_cache dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .mem        (mif),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  typedef struct {
    string       name;
    logic        is_load;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b1;
  logic auto_ack = 1'b1;
  int   manual_req = 0;
  int   txn_cnt  = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  logic [31:0] last_rd_addr = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Backing memory: acks the third cycle it sees a request.
  initial begin : responder
    logic [31:0] bmem [logic [31:0]];
    int lat;
    int manual_seen;
    lat = 0;
    manual_seen = 0;
    bmem[32'h0000_0100] = 32'hDEAD_BEEF;
    bmem[32'h0000_0104] = 32'h0000_1111;
    mif.mem_ack_i   = 1'b0;
    mif.mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (mif.mem_ack_i) begin
        mif.mem_ack_i = 1'b0;
        lat = 0;
      end else if (manual_req != manual_seen) begin
        manual_seen     = manual_req;
        mif.mem_rdata_i = 32'hBAD0_BAD0;
        mif.mem_ack_i   = 1'b1;
      end else if (auto_ack && mif.mem_req_o) begin
        lat++;
        if (lat == 3) begin
          if (mif.mem_we_o) begin
            bmem[mif.mem_addr_o] = mif.mem_wdata_o;
            last_wr_addr = mif.mem_addr_o;
            last_wr_data = mif.mem_wdata_o;
          end else begin
            mif.mem_rdata_i = bmem.exists(mif.mem_addr_o) ? bmem[mif.mem_addr_o] : 32'h0;
            last_rd_addr = mif.mem_addr_o;
          end
          txn_cnt++;
          mif.mem_ack_i = 1'b1;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Monitor: every retiring access (req_i with stall_o low) pops one expectation.
  initial begin : monitor
    int   stall_run;
    exp_t e;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        stall_run = 0;
      end else if (mon_en && req_i) begin
        if (stall_o) begin
          stall_run++;
        end else if (sb_q.size() == 0) begin
          check("unexpected_completion", 32'h1, 32'h0);
        end else begin
          e = sb_q.pop_front();
          if (e.is_load) begin
            check({e.name, "_rdata"}, rdata_o, e.rdata);
          end
          check({e.name, "_stalls"}, stall_run, e.stalls);
          stall_run = 0;
        end
      end
    end
  end

  task automatic do_op(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input int exp_stalls);
    exp_t e;
    int   c;
    logic done;
    e.name = name; e.is_load = !we; e.rdata = exp_rd; e.stalls = exp_stalls;
    sb_q.push_back(e);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    c = 0; done = 1'b0;
    while (!done && c < 60) begin
      @(negedge clk);
      if (!stall_o) done = 1'b1;
      c++;
    end
    check({name, "_completes"}, {31'h0, done}, 32'h1);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  initial begin : driver
    int t;
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_mem_req", {31'h0, mif.mem_req_o}, 32'h0);
    check("rst_mem_we", {31'h0, mif.mem_we_o}, 32'h0);
    check("rst_mem_addr", mif.mem_addr_o, 32'h0);
    check("rst_hit_cnt", {16'h0, hit_cnt_o}, 32'h0);
    check("rst_miss_cnt", {16'h0, miss_cnt_o}, 32'h0);
    rst_i = 1'b1;
    @(posedge clk); #1;

    do_op("ld_miss_100", 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4);
    check("miss_cnt_1", {16'h0, miss_cnt_o}, 32'd1);
    t = txn_cnt;
    do_op("ld_hit_100", 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    check("hit_cnt_1", {16'h0, hit_cnt_o}, 32'd1);
    check("hit_no_mem_txn", t, txn_cnt);
    check("hit_mem_req_low", {31'h0, mif.mem_req_o}, 32'h0);

    do_op("st_100", 1'b1, 32'h100, 32'h1234_5678, 32'h0, 4);
    check("st_100_addr", last_wr_addr, 32'h100);
    check("st_100_data", last_wr_data, 32'h1234_5678);
    check("hit_cnt_2", {16'h0, hit_cnt_o}, 32'd2);
    do_op("ld_after_st", 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0);
    check("hit_cnt_3", {16'h0, hit_cnt_o}, 32'd3);

    do_op("st_140", 1'b1, 32'h140, 32'hCAFE_F00D, 32'h0, 4);
    check("st_140_addr", last_wr_addr, 32'h140);
    check("miss_cnt_2", {16'h0, miss_cnt_o}, 32'd2);
    do_op("ld_100_untouched", 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0);
    check("hit_cnt_4", {16'h0, hit_cnt_o}, 32'd4);
    do_op("ld_140_no_alloc", 1'b0, 32'h140, 32'h0, 32'hCAFE_F00D, 4);
    do_op("ld_103_evicted", 1'b0, 32'h103, 32'h0, 32'h1234_5678, 4);
    check("ld_103_aligned", last_rd_addr, 32'h100);
    check("miss_cnt_4", {16'h0, miss_cnt_o}, 32'd4);

    // Reset in the middle of a fetch, followed by a stray ack.
    auto_ack = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h104;
    repeat (2) @(posedge clk);
    #1;
    check("fetch_req_high", {31'h0, mif.mem_req_o}, 32'h1);
    rst_i = 1'b0; req_i = 1'b0;
    #1;
    check("midrst_mem_req", {31'h0, mif.mem_req_o}, 32'h0);
    check("midrst_stall", {31'h0, stall_o}, 32'h0);
    check("midrst_miss_cnt", {16'h0, miss_cnt_o}, 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    manual_req++;
    repeat (3) @(posedge clk);
    #1;
    check("stray_ack_mem_req", {31'h0, mif.mem_req_o}, 32'h0);
    auto_ack = 1'b1;
    do_op("ld_104_after_rst", 1'b0, 32'h104, 32'h0, 32'h0000_1111, 4);
    do_op("ld_100_after_rst", 1'b0, 32'h100, 32'h0, 32'h1234_5678, 4);
    check("miss_cnt_after_rst", {16'h0, miss_cnt_o}, 32'd2);

    // Idle cycle: no request means quiet outputs.
    @(negedge clk);
    check("idle_stall", {31'h0, stall_o}, 32'h0);
    check("idle_rdata", rdata_o, 32'h0);
    @(posedge clk); #1;

    // Saturation of the hit counter.
    mon_en = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100;
    repeat (70000) @(posedge clk);
    #1;
    req_i = 1'b0;
    check("hit_cnt_sat", {16'h0, hit_cnt_o}, 32'h0000_FFFF);
    check("miss_cnt_steady", {16'h0, miss_cnt_o}, 32'd2);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
